altair_rom_loader: RTL and testbench

// - Bridges the hps_io ioctl download stream (F0 "Load Program") into Altair main memory.
// - Sits between hps_io and the altair machine's memory write port.
// - Holds the CPU off the bus during a download, writes each byte with a req/ack handshake,

---
 rtl/altair_pkg.sv | 15 +
 rtl/altair_rom_loader.sv | 112 +++++++++++
 tb/tb_altair_rom_loader.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/altair_pkg.sv
// Shared types for the Altair program loader: FSM state encoding and the
// hps_io file slot used for "Load Program".
package altair_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HOLD   = 3'd1,
    STREAM = 3'd2,
    WRITE  = 3'd3,
    DONE   = 3'd4
  } loader_state_t;

  localparam logic [7:0] FILE_IDX_PROGRAM = 8'd0;

endpackage

// File: rtl/altair_rom_loader.sv
// Moves the hps_io ioctl download stream into Altair main memory: holds the CPU
// off the bus, writes one byte at a time with req/ack, and pulses prg_load at the end.
module altair_rom_loader
  import altair_pkg::*;
#(
  parameter int                ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] LOAD_BASE = '0,
  parameter int                MAX_BYTES = 65536,
  parameter logic [7:0]        FILE_IDX  = FILE_IDX_PROGRAM
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              ioctl_wait,
  output logic              hold_req,
  input  logic              hold_ack,
  output logic              mem_req,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              prg_load,
  output logic              loading,
  output logic              overflow
);

  localparam int                CNT_W      = $clog2(MAX_BYTES + 1);
  localparam logic [25:0]       ADDR_LIMIT = 26'(MAX_BYTES);
  localparam logic [CNT_W-1:0]  CNT_LIMIT  = CNT_W'(MAX_BYTES);

  loader_state_t     state, state_nxt;
  logic [CNT_W-1:0]  byte_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        data_q;
  logic              ovf_q;
  logic              in_range;
  logic              accept;
  logic              dl_start;

  // A byte is taken only if its offset fits and the per-download byte budget is not used up.
  assign in_range = ({1'b0, ioctl_addr} < ADDR_LIMIT);
  assign accept   = ioctl_wr && in_range && (byte_cnt < CNT_LIMIT);
  assign dl_start = (state == IDLE) && ioctl_download && (ioctl_index == FILE_IDX);

  assign mem_addr = addr_q;
  assign mem_data = data_q;
  assign overflow = ovf_q;

  always_comb begin
    state_nxt  = state;
    hold_req   = 1'b0;
    ioctl_wait = 1'b0;
    mem_req    = 1'b0;
    prg_load   = 1'b0;
    loading    = (state != IDLE);
    case (state)
      IDLE: begin
        if (dl_start) state_nxt = HOLD;
      end
      HOLD: begin
        hold_req   = 1'b1;
        ioctl_wait = 1'b1;
        if (hold_ack) state_nxt = ioctl_download ? STREAM : DONE;
      end
      STREAM: begin
        hold_req = 1'b1;
        if (accept)               state_nxt = WRITE;
        else if (!ioctl_download) state_nxt = DONE;
      end
      WRITE: begin
        hold_req   = 1'b1;
        ioctl_wait = 1'b1;
        mem_req    = 1'b1;
        // A download that ended mid-write goes straight to DONE once the byte lands.
        if (mem_ack) state_nxt = ioctl_download ? STREAM : DONE;
      end
      DONE: begin
        prg_load  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      byte_cnt <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (dl_start) begin
        byte_cnt <= '0;
        ovf_q    <= 1'b0;
      end
      if ((state == STREAM) && accept) begin
        addr_q <= LOAD_BASE + ioctl_addr[ADDR_W-1:0];
        data_q <= ioctl_dout;
      end
      // Rejected offsets and strobes that arrive while a write is outstanding are both lost bytes.
      if ((state == STREAM) && ioctl_wr && !accept) ovf_q <= 1'b1;
      if ((state == WRITE) && ioctl_wr)             ovf_q <= 1'b1;
      if ((state == WRITE) && mem_ack)              byte_cnt <= byte_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_altair_rom_loader.sv
// Bench for altair_rom_loader: two instances (LOAD_BASE 0000 and FFFE) share one
// ioctl stream; a bus/memory responder logs every completed write.
module tb_altair_rom_loader;
  import altair_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, ioctl_download, ioctl_wr, hold_ack;
  logic [7:0]  ioctl_index, ioctl_dout;
  logic [24:0] ioctl_addr;
  logic        ioctl_wait [2];
  logic        hold_req   [2];
  logic        mem_req    [2];
  logic        mem_ack    [2];
  logic        prg_load   [2];
  logic        loading    [2];
  logic        overflow   [2];
  logic [15:0] mem_addr   [2];
  logic [7:0]  mem_data   [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    altair_rom_loader #(
      .ADDR_W(16), .LOAD_BASE((g == 0) ? 16'h0000 : 16'hFFFE),
      .MAX_BYTES(65536), .FILE_IDX(FILE_IDX_PROGRAM)
    ) dut (
      .clk(clk), .reset_n(reset_n), .ioctl_download(ioctl_download),
      .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
      .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait[g]), .hold_req(hold_req[g]),
      .hold_ack(hold_ack), .mem_req(mem_req[g]), .mem_ack(mem_ack[g]),
      .mem_addr(mem_addr[g]), .mem_data(mem_data[g]), .prg_load(prg_load[g]),
      .loading(loading[g]), .overflow(overflow[g])
    );
  end

  typedef struct packed {logic [15:0] a; logic [7:0] d;} wr_t;
  typedef struct {logic [24:0] addr; logic [7:0] data; bit wr; logic [15:0] ea0; logic [15:0] ea1;} vec_t;

  int n_tests = 0;
  int n_fail  = 0;
  int ack_dly = 1;
  int hold_dly = 0;
  int hcnt = 0;
  int acnt [2];
  int pl_cnt [2];
  logic pl_prev [2];
  logic [23:0] held [2];
  wr_t wlog0[$], wlog1[$], exp0[$], exp1[$];
  logic exp_ovf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] outs(input int i);
    return {2'b00, ioctl_wait[i], hold_req[i], mem_req[i], prg_load[i], loading[i],
            overflow[i], mem_addr[i], mem_data[i]};
  endfunction

  // Bus/memory responder, hold_ack generator and prg_load monitor.
  initial begin
    hold_ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mem_ack[i] = 1'b0; acnt[i] = 0; pl_cnt[i] = 0; pl_prev[i] = 1'b0; held[i] = '0;
    end
    forever begin
      @(negedge clk);
      if (hold_req[0]) begin
        hcnt++;
        hold_ack = (hcnt > hold_dly);
      end else begin
        hcnt = 0;
        hold_ack = 1'b0;
      end
      for (int i = 0; i < 2; i++) begin
        if (prg_load[i]) begin
          pl_cnt[i]++;
          check("prg_load_width", 32'(pl_prev[i]), 32'd0);
        end
        pl_prev[i] = prg_load[i];
        if (mem_ack[i]) begin
          mem_ack[i] = 1'b0;
          check("ack_to_wait_low", 32'(ioctl_wait[i]), 32'd0);
          check("ack_drops_req", 32'(mem_req[i]), 32'd0);
        end else if (mem_req[i] && reset_n) begin
          if (acnt[i] == 0) held[i] = {mem_addr[i], mem_data[i]};
          else check("req_stable", 32'({mem_addr[i], mem_data[i]}), 32'(held[i]));
          if (acnt[i] >= ack_dly) begin
            if (i == 0) wlog0.push_back({mem_addr[i], mem_data[i]});
            else        wlog1.push_back({mem_addr[i], mem_data[i]});
            mem_ack[i] = 1'b1;
            acnt[i] = 0;
          end else acnt[i]++;
        end else acnt[i] = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic start_dl(input logic [7:0] idx);
    @(negedge clk);
    ioctl_index = idx;
    ioctl_download = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d, input bit exp_wr);
    int t;
    t = 0;
    while (ioctl_wait[0] && t < 400) begin
      @(negedge clk);
      t++;
    end
    check("wait_release_bound", 32'(t < 400), 32'd1);
    ioctl_wr = 1'b1; ioctl_addr = a; ioctl_dout = d;
    @(negedge clk);
    ioctl_wr = 1'b0;
    check("wr_to_mem_req", 32'({mem_req[0], mem_req[1]}), exp_wr ? 32'd3 : 32'd0);
    check("wr_to_wait", 32'(ioctl_wait[0]), 32'(exp_wr));
  endtask

  task automatic end_dl(input int exp_pl);
    int t, b0, b1;
    t = 0; b0 = pl_cnt[0]; b1 = pl_cnt[1];
    ioctl_download = 1'b0;
    @(negedge clk);
    while (loading[0] && t < 400) begin
      @(negedge clk);
      t++;
    end
    check("done_bound", 32'(t < 400), 32'd1);
    @(negedge clk);
    check("prg_load_count0", 32'(pl_cnt[0] - b0), 32'(exp_pl));
    check("prg_load_count1", 32'(pl_cnt[1] - b1), 32'(exp_pl));
    check("hold_req_after", 32'({hold_req[0], hold_req[1]}), 32'd0);
  endtask

  // Reference model: an accepted byte lands at base + offset modulo 64K; others only flag overflow.
  task automatic expect_byte(input logic [24:0] a, input logic [7:0] d);
    if (a < 25'h10000) begin
      exp0.push_back({a[15:0], d});
      exp1.push_back({a[15:0] + 16'hFFFE, d});
    end else exp_ovf = 1'b1;
  endtask

  task automatic compare_logs(input string tag);
    wr_t e, g;
    check({tag, "_count0"}, 32'(wlog0.size()), 32'(exp0.size()));
    check({tag, "_count1"}, 32'(wlog1.size()), 32'(exp1.size()));
    while (exp0.size() > 0) begin
      e = exp0.pop_front();
      g = (wlog0.size() > 0) ? wlog0.pop_front() : '1;
      check({tag, "_write0"}, 32'(g), 32'(e));
    end
    while (exp1.size() > 0) begin
      e = exp1.pop_front();
      g = (wlog1.size() > 0) ? wlog1.pop_front() : '1;
      check({tag, "_write1"}, 32'(g), 32'(e));
    end
    wlog0.delete(); wlog1.delete();
  endtask

  vec_t tbl [8];
  logic ovf_t;
  int nb, nwr;
  logic [24:0] ra;
  logic [7:0] rd;
  wr_t gw;

  initial begin
    tbl[0] = '{25'h0000000, 8'hAA, 1'b1, 16'h0000, 16'hFFFE};
    tbl[1] = '{25'h0000001, 8'hBB, 1'b1, 16'h0001, 16'hFFFF};
    tbl[2] = '{25'h0000002, 8'hCC, 1'b1, 16'h0002, 16'h0000};
    tbl[3] = '{25'h0000003, 8'hDD, 1'b1, 16'h0003, 16'h0001};
    tbl[4] = '{25'h000FFFF, 8'h5E, 1'b1, 16'hFFFF, 16'hFFFD};
    tbl[5] = '{25'h0010000, 8'h66, 1'b0, 16'h0000, 16'h0000};
    tbl[6] = '{25'h1FFFFFF, 8'h77, 1'b0, 16'h0000, 16'h0000};
    tbl[7] = '{25'h0008001, 8'h3C, 1'b1, 16'h8001, 16'h7FFF};

    reset_n = 1'b0; ioctl_download = 1'b0; ioctl_index = 8'd0; ioctl_wr = 1'b0;
    ioctl_addr = '0; ioctl_dout = '0; exp_ovf = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outs0", outs(0), 32'd0);
    check("reset_outs1", outs(1), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Table-driven download, ack two cycles after each req; last byte ends mid-write.
    ack_dly = 1; ovf_t = 1'b0; nwr = 0;
    start_dl(8'd0);
    check("loading_in_hold", 32'({loading[0], hold_req[0], ioctl_wait[0]}), 32'd7);
    for (int i = 0; i < 8; i++) begin
      send_byte(tbl[i].addr, tbl[i].data, tbl[i].wr);
      if (!tbl[i].wr) ovf_t = 1'b1;
      else nwr++;
      check("tbl_overflow", 32'({overflow[0], overflow[1]}), ovf_t ? 32'd3 : 32'd0);
    end
    end_dl(1);
    check("tbl_count0", 32'(wlog0.size()), 32'(nwr));
    check("tbl_count1", 32'(wlog1.size()), 32'(nwr));
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].wr) begin
        gw = (wlog0.size() > 0) ? wlog0.pop_front() : '1;
        check("tbl_write0", 32'(gw), 32'({tbl[i].ea0, tbl[i].data}));
        gw = (wlog1.size() > 0) ? wlog1.pop_front() : '1;
        check("tbl_write1", 32'(gw), 32'({tbl[i].ea1, tbl[i].data}));
      end
    end
    wlog0.delete(); wlog1.delete();

    // hold_ack withheld: bus stays requested and hps_io stalled, then a normal stream.
    hold_dly = 20; exp_ovf = 1'b0;
    start_dl(8'd0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("hold_wait_stall", 32'({ioctl_wait[0], mem_req[0], hold_req[0]}), 32'b101);
    end
    expect_byte(25'h20, 8'h01); send_byte(25'h20, 8'h01, 1'b1);
    expect_byte(25'h21, 8'h02); send_byte(25'h21, 8'h02, 1'b1);
    end_dl(1);
    compare_logs("hold");
    hold_dly = 0;

    // Out-of-range offset only: nothing written, overflow sticky, prg_load still pulses.
    exp_ovf = 1'b0;
    start_dl(8'd0);
    expect_byte(25'h10000, 8'h99); send_byte(25'h10000, 8'h99, 1'b0);
    end_dl(1);
    compare_logs("ovf");
    check("ovf_sticky", 32'({overflow[0], overflow[1]}), 32'd3);

    // Next download clears overflow; a strobe during WRITE is dropped and flagged.
    ack_dly = 5; exp_ovf = 1'b0;
    start_dl(8'd0);
    check("ovf_cleared", 32'({overflow[0], overflow[1]}), 32'd0);
    expect_byte(25'h7, 8'h77); send_byte(25'h7, 8'h77, 1'b1);
    ioctl_wr = 1'b1; ioctl_addr = 25'h8; ioctl_dout = 8'h88;
    @(negedge clk);
    ioctl_wr = 1'b0;
    check("wr_in_write_ovf", 32'({overflow[0], overflow[1]}), 32'd3);
    end_dl(1);
    compare_logs("wrwr");

    // Download drops while still in HOLD, and a zero-byte download.
    ack_dly = 1; hold_dly = 5;
    start_dl(8'd0);
    end_dl(1);
    hold_dly = 0;
    start_dl(8'd0);
    end_dl(1);
    compare_logs("empty");

    // Foreign file slot is ignored entirely.
    start_dl(8'd1);
    send_byte(25'h0, 8'h12, 1'b0);
    repeat (4) @(negedge clk);
    check("idx1_idle", 32'({loading[0], hold_req[0], loading[1], hold_req[1]}), 32'd0);
    end_dl(0);
    compare_logs("idx1");

    // Asynchronous reset in the middle of a write.
    ack_dly = 50;
    start_dl(8'd0);
    send_byte(25'h5, 8'h5A, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset0", outs(0), 32'd0);
    check("async_reset1", outs(1), 32'd0);
    ioctl_download = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_reset_idle", 32'({loading[0], loading[1]}), 32'd0);
    wlog0.delete(); wlog1.delete();
    ack_dly = 1; exp_ovf = 1'b0;
    start_dl(8'd0);
    expect_byte(25'h10, 8'hA1); send_byte(25'h10, 8'hA1, 1'b1);
    expect_byte(25'h11, 8'hB2); send_byte(25'h11, 8'hB2, 1'b1);
    end_dl(1);
    compare_logs("fresh");

    // Randomized downloads against the model.
    for (int r = 0; r < 10; r++) begin
      nb = $urandom_range(1, 6);
      ack_dly = $urandom_range(0, 3);
      hold_dly = $urandom_range(0, 3);
      exp_ovf = 1'b0;
      start_dl(8'd0);
      for (int k = 0; k < nb; k++) begin
        if ($urandom_range(0, 4) == 0) ra = 25'(32'h10000 + $urandom_range(0, 32'h1FFFF));
        else ra = 25'($urandom_range(0, 32'hFFFF));
        rd = 8'($urandom);
        expect_byte(ra, rd);
        send_byte(ra, rd, ra < 25'h10000);
      end
      end_dl(1);
      compare_logs("rnd");
      check("rnd_overflow", 32'({overflow[0], overflow[1]}), exp_ovf ? 32'd3 : 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
